// File: rtl/instr_controller_pkg.sv
// Shared types and instruction-field positions for the instruction controller.
package instr_controller_pkg;

  localparam int unsigned OP_MSB = 9;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RX_MSB = 5;
  localparam int unsigned RX_LSB = 3;
  localparam int unsigned RY_MSB = 2;
  localparam int unsigned RY_LSB = 0;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;
  localparam int unsigned REG_W  = RX_MSB - RX_LSB + 1;

  typedef enum logic [OP_W-1:0] {
    OP_LD  = 4'b0000,
    OP_MV  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011
  } opcode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Scalar control strobes produced by the decoder
  typedef struct packed {
    logic ext_out;
    logic a_ld;
    logic g_ld;
    logic g_out;
    logic alu_sub;
    logic clr;
    logic done;
    logic ill;
  } ctrl_t;

endpackage

// File: rtl/instr_controller_if.sv
// Control/handshake bundle between the instruction controller and its datapath.
interface instr_controller_if #(
  parameter int unsigned W    = 10,
  parameter int unsigned NREG = 8
);
  logic [1:0]      CNT;
  logic            EXEC;
  logic [W-1:0]    INSTR;
  logic            CLR;
  logic            IR_LD;
  logic            EXT_OUT;
  logic            A_LD;
  logic            G_LD;
  logic            G_OUT;
  logic            ALU_SUB;
  logic [NREG-1:0] RIN;
  logic [NREG-1:0] ROUT;
  logic            DONE;
  logic            ILL;
  logic            ERR;

  modport slave (
    input  CNT, EXEC, INSTR,
    output CLR, IR_LD, EXT_OUT, A_LD, G_LD, G_OUT, ALU_SUB, RIN, ROUT, DONE, ILL, ERR
  );

  modport master (
    output CNT, EXEC, INSTR,
    input  CLR, IR_LD, EXT_OUT, A_LD, G_LD, G_OUT, ALU_SUB, RIN, ROUT, DONE, ILL, ERR
  );
endinterface

// File: rtl/instr_controller_decode.sv
// Combinational decode of (IR, timestep) into per-step control strobes.
module instr_decode
  import instr_controller_pkg::*;
#(
  parameter int unsigned W    = 10,
  parameter int unsigned NREG = 8
) (
  input  logic [W-1:0]    ir,
  input  logic [1:0]      cnt,
  output ctrl_t           flags,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rx;
  logic [REG_W-1:0] ry;

  assign op = ir[OP_MSB:OP_LSB];
  assign rx = ir[RX_MSB:RX_LSB];
  assign ry = ir[RY_MSB:RY_LSB];

  always_comb begin
    flags = '0;
    rin   = '0;
    rout  = '0;
    case (op)
      OP_LD: begin
        if (cnt == 2'd1) begin
          flags.ext_out = 1'b1;
          rin           = NREG'(1) << rx;
          flags.clr     = 1'b1;
          flags.done    = 1'b1;
        end
      end
      OP_MV: begin
        if (cnt == 2'd1) begin
          rout       = NREG'(1) << ry;
          rin        = NREG'(1) << rx;
          flags.clr  = 1'b1;
          flags.done = 1'b1;
        end
      end
      OP_ADD, OP_SUB: begin
        case (cnt)
          2'd1: begin
            rout       = NREG'(1) << rx;
            flags.a_ld = 1'b1;
          end
          2'd2: begin
            rout          = NREG'(1) << ry;
            flags.g_ld    = 1'b1;
            flags.alu_sub = (op == OP_SUB);
          end
          2'd3: begin
            flags.g_out = 1'b1;
            rin         = NREG'(1) << rx;
            flags.clr   = 1'b1;
            flags.done  = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        // Unknown opcode: flag and retire without touching registers
        if (cnt == 2'd1) begin
          flags.ill  = 1'b1;
          flags.clr  = 1'b1;
          flags.done = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_controller.sv
// Instruction sequencer: IDLE/RUN state, IR, expected-step tracking and sticky step-mismatch error.
module instr_controller
  import instr_controller_pkg::*;
#(
  parameter int unsigned W    = 10,
  parameter int unsigned NREG = 8
) (
  input  logic              CLKb,
  input  logic              CLRb,
  instr_controller_if.slave bus
);

  state_e          state_q;
  state_e          state_d;
  logic [W-1:0]    ir_q;
  logic [1:0]      step_q;
  logic            err_q;

  ctrl_t           dec_flags;
  logic [NREG-1:0] dec_rin;
  logic [NREG-1:0] dec_rout;

  ctrl_t           flags;
  logic [NREG-1:0] rin;
  logic [NREG-1:0] rout;
  logic            ir_ld;
  logic            mismatch;

  instr_decode #(.W(W), .NREG(NREG)) u_decode (
    .ir    (ir_q),
    .cnt   (bus.CNT),
    .flags (dec_flags),
    .rin   (dec_rin),
    .rout  (dec_rout)
  );

  // Next state and output selection; reset and step mismatch override the decoder
  always_comb begin
    flags    = '0;
    rin      = '0;
    rout     = '0;
    ir_ld    = 1'b0;
    mismatch = 1'b0;
    state_d  = state_q;
    if (!CLRb) begin
      flags.clr = 1'b1;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.EXEC && (bus.CNT == 2'd0)) begin
            ir_ld   = 1'b1;
            state_d = S_RUN;
          end else begin
            flags.clr = 1'b1;
          end
        end
        S_RUN: begin
          if (bus.CNT != step_q) begin
            mismatch  = 1'b1;
            flags.clr = 1'b1;
            state_d   = S_IDLE;
          end else begin
            flags = dec_flags;
            rin   = dec_rin;
            rout  = dec_rout;
            if (dec_flags.clr) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          flags.clr = 1'b1;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge CLKb) begin
    if (!CLRb) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      step_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_ld) begin
        ir_q <= bus.INSTR;
      end
      if (mismatch) begin
        err_q <= 1'b1;
      end
      if (ir_ld) begin
        step_q <= 2'd1;
      end else if (state_q == S_RUN) begin
        step_q <= flags.clr ? 2'd0 : step_q + 2'd1;
      end
    end
  end

  assign bus.CLR     = flags.clr;
  assign bus.IR_LD   = ir_ld;
  assign bus.EXT_OUT = flags.ext_out;
  assign bus.A_LD    = flags.a_ld;
  assign bus.G_LD    = flags.g_ld;
  assign bus.G_OUT   = flags.g_out;
  assign bus.ALU_SUB = flags.alu_sub;
  assign bus.RIN     = rin;
  assign bus.ROUT    = rout;
  assign bus.DONE    = flags.done;
  assign bus.ILL     = flags.ill;
  // Sticky error is masked while reset is held so every output but CLR reads 0
  assign bus.ERR     = err_q & CLRb;

endmodule

// File: tb/tb_instr_controller.sv
// Directed self-checking bench for instr_controller; CNT is driven per step as the timestep counter would.
module tb_instr_controller;

  localparam logic [9:0] C_IRLD = 10'b10_0000_0000;
  localparam logic [9:0] C_EXT  = 10'b01_0000_0000;
  localparam logic [9:0] C_ALD  = 10'b00_1000_0000;
  localparam logic [9:0] C_GLD  = 10'b00_0100_0000;
  localparam logic [9:0] C_GOUT = 10'b00_0010_0000;
  localparam logic [9:0] C_SUB  = 10'b00_0001_0000;
  localparam logic [9:0] C_CLR  = 10'b00_0000_1000;
  localparam logic [9:0] C_DONE = 10'b00_0000_0100;
  localparam logic [9:0] C_ILL  = 10'b00_0000_0010;
  localparam logic [9:0] C_ERR  = 10'b00_0000_0001;

  localparam logic [9:0] I_LD   = 10'b0000_011_000;
  localparam logic [9:0] I_ADD  = 10'b0010_001_010;
  localparam logic [9:0] I_SUB  = 10'b0011_010_011;
  localparam logic [9:0] I_MV   = 10'b0001_101_110;
  localparam logic [9:0] I_BAD  = 10'b1111_000_000;

  logic CLKb;
  logic CLRb;
  int   errors = 0;
  int   checks = 0;

  instr_controller_if #(.W(10), .NREG(8)) bus ();

  instr_controller #(.W(10), .NREG(8)) dut (
    .CLKb (CLKb),
    .CLRb (CLRb),
    .bus  (bus)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  function automatic logic [25:0] ex(input logic [9:0] c, input logic [7:0] rin, input logic [7:0] rout);
    return {c, rin, rout};
  endfunction

  // Apply inputs for one cycle, check mid-cycle at the rising edge, then advance past the falling edge
  task automatic step(input logic clrb, input logic exec, input logic [1:0] cnt,
                      input logic [9:0] instr, input string tag, input logic [25:0] exp);
    logic [25:0] obs;
    CLRb      = clrb;
    bus.EXEC  = exec;
    bus.CNT   = cnt;
    bus.INSTR = instr;
    @(posedge CLKb);
    #1;
    obs = {bus.IR_LD, bus.EXT_OUT, bus.A_LD, bus.G_LD, bus.G_OUT, bus.ALU_SUB,
           bus.CLR, bus.DONE, bus.ILL, bus.ERR, bus.RIN, bus.ROUT};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    @(negedge CLKb);
    #1;
  endtask

  initial begin
    CLRb      = 1'b0;
    bus.EXEC  = 1'b0;
    bus.CNT   = 2'd0;
    bus.INSTR = '0;

    // Reset
    step(0, 0, 2'd0, I_LD, "rst_idle", ex(C_CLR, 8'h00, 8'h00));
    step(0, 1, 2'd0, I_LD, "rst_exec", ex(C_CLR, 8'h00, 8'h00));
    step(1, 0, 2'd0, I_LD, "idle",     ex(C_CLR, 8'h00, 8'h00));
    step(1, 1, 2'd1, I_LD, "retry",    ex(C_CLR, 8'h00, 8'h00));

    // LD R3 <- ext; INSTR changed after load must not matter
    step(1, 1, 2'd0, I_LD,  "ld_t0",  ex(C_IRLD, 8'h00, 8'h00));
    step(1, 0, 2'd1, I_BAD, "ld_t1",  ex(C_EXT | C_CLR | C_DONE, 8'h08, 8'h00));
    step(1, 0, 2'd0, I_BAD, "ld_end", ex(C_CLR, 8'h00, 8'h00));

    // ADD R1 <- R1 + R2, EXEC held during RUN
    step(1, 1, 2'd0, I_ADD, "add_t0", ex(C_IRLD, 8'h00, 8'h00));
    step(1, 1, 2'd1, I_ADD, "add_t1", ex(C_ALD, 8'h00, 8'h02));
    step(1, 1, 2'd2, I_ADD, "add_t2", ex(C_GLD, 8'h00, 8'h04));
    step(1, 0, 2'd3, I_ADD, "add_t3", ex(C_GOUT | C_CLR | C_DONE, 8'h02, 8'h00));
    step(1, 0, 2'd0, I_ADD, "add_end", ex(C_CLR, 8'h00, 8'h00));

    // SUB R2 <- R2 - R3 back-to-back with MV R5 <- R6
    step(1, 1, 2'd0, I_SUB, "sub_t0", ex(C_IRLD, 8'h00, 8'h00));
    step(1, 1, 2'd1, I_MV,  "sub_t1", ex(C_ALD, 8'h00, 8'h04));
    step(1, 1, 2'd2, I_MV,  "sub_t2", ex(C_GLD | C_SUB, 8'h00, 8'h08));
    step(1, 1, 2'd3, I_MV,  "sub_t3", ex(C_GOUT | C_CLR | C_DONE, 8'h04, 8'h00));
    step(1, 1, 2'd0, I_MV,  "mv_t0",  ex(C_IRLD, 8'h00, 8'h00));
    step(1, 0, 2'd1, I_MV,  "mv_t1",  ex(C_CLR | C_DONE, 8'h20, 8'h40));
    step(1, 0, 2'd0, I_MV,  "mv_end", ex(C_CLR, 8'h00, 8'h00));

    // Illegal opcode
    step(1, 1, 2'd0, I_BAD, "ill_t0",  ex(C_IRLD, 8'h00, 8'h00));
    step(1, 0, 2'd1, I_BAD, "ill_t1",  ex(C_ILL | C_CLR | C_DONE, 8'h00, 8'h00));
    step(1, 0, 2'd0, I_BAD, "ill_end", ex(C_CLR, 8'h00, 8'h00));

    // Step mismatch during ADD T1, sticky ERR until reset
    step(1, 1, 2'd0, I_ADD, "mm_t0",   ex(C_IRLD, 8'h00, 8'h00));
    step(1, 0, 2'd3, I_ADD, "mm_t1",   ex(C_CLR, 8'h00, 8'h00));
    step(1, 0, 2'd0, I_ADD, "mm_err",  ex(C_CLR | C_ERR, 8'h00, 8'h00));
    step(1, 1, 2'd0, I_LD,  "mm_ld0",  ex(C_IRLD | C_ERR, 8'h00, 8'h00));
    step(1, 0, 2'd1, I_LD,  "mm_ld1",  ex(C_EXT | C_CLR | C_DONE | C_ERR, 8'h08, 8'h00));
    step(1, 0, 2'd0, I_LD,  "mm_hold", ex(C_CLR | C_ERR, 8'h00, 8'h00));
    step(0, 0, 2'd0, I_LD,  "mm_rst",  ex(C_CLR, 8'h00, 8'h00));
    step(1, 0, 2'd0, I_LD,  "mm_clr",  ex(C_CLR, 8'h00, 8'h00));

    // Reset during ADD T2 aborts with no register write
    step(1, 1, 2'd0, I_ADD, "ra_t0",   ex(C_IRLD, 8'h00, 8'h00));
    step(1, 0, 2'd1, I_ADD, "ra_t1",   ex(C_ALD, 8'h00, 8'h02));
    step(0, 0, 2'd2, I_ADD, "ra_rst",  ex(C_CLR, 8'h00, 8'h00));
    step(1, 0, 2'd0, I_ADD, "ra_idle", ex(C_CLR, 8'h00, 8'h00));
    step(1, 0, 2'd3, I_ADD, "ra_cnt3", ex(C_CLR, 8'h00, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
